// File: rtl/stoch_signed_mmult_window_ctrl_pkg.sv
// Shared types and width helpers for the signed stochastic matrix-multiply window controller.
package stoch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    WARMUP = 3'd2,
    ACCUM  = 3'd3,
    DONE   = 3'd4
  } ctrl_state_t;

  // A ones-counter must hold the value WINDOW_LEN itself, hence the +1.
  function automatic int cnt_width(input int window_len);
    if (window_len < 1) begin
      return 1;
    end
    return $clog2(window_len + 1);
  endfunction

  // The window counter only ever holds (length - 1) of the longer phase.
  function automatic int win_width(input int window_len, input int pipe_delay);
    int longest;
    longest = (window_len > pipe_delay) ? window_len : pipe_delay;
    if (longest < 2) begin
      return 1;
    end
    return $clog2(longest);
  endfunction

endpackage

// File: rtl/stoch_signed_mmult_window_ctrl_ones_counter.sv
// Saturation-free ones counter for one bitstream; clear has priority over counting.
module stoch_ones_counter #(
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      r_count <= '0;
    end else if (en && bit_in) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/stoch_signed_mmult_window_ctrl.sv
// Window sequencer: flush, pipeline warm-up, ones counting, then a held signed
// estimate (plus minus minus) per element behind a valid/ready handshake.
module stoch_signed_mmult_window_ctrl
  import stoch_ctrl_pkg::*;
#(
  parameter int NUM_ROWS   = 2,
  parameter int NUM_COLS   = 2,
  parameter int WINDOW_LEN = 256,
  parameter int PIPE_DELAY = 2,
  parameter int CNT_W      = cnt_width(WINDOW_LEN)
) (
  input  logic                                        CLK,
  input  logic                                        RST,
  input  logic                                        start,
  input  logic                                        abort,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]           Y_p,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]           Y_m,
  output logic                                        dp_rst,
  output logic                                        dp_en,
  output logic                                        busy,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][CNT_W:0]  result,
  output logic                                        result_valid,
  input  logic                                        result_ready
);

  localparam int RW    = CNT_W + 1;
  localparam int WIN_W = win_width(WINDOW_LEN, PIPE_DELAY);
  localparam logic [WIN_W-1:0] WARM_LOAD = WIN_W'((PIPE_DELAY > 0) ? PIPE_DELAY - 1 : 0);
  localparam logic [WIN_W-1:0] ACC_LOAD  = WIN_W'(WINDOW_LEN - 1);

  ctrl_state_t r_state;
  ctrl_state_t w_state_next;

  logic [WIN_W-1:0] r_win;
  logic             w_win_done;

  logic r_dp_rst;
  logic r_dp_en;
  logic r_busy;
  logic r_valid;
  logic w_dp_rst_next;
  logic w_dp_en_next;
  logic w_busy_next;
  logic w_valid_next;

  logic w_clr;
  logic w_acc_en;
  logic w_load_result;

  logic [NUM_ROWS-1:0][NUM_COLS-1:0][CNT_W-1:0] w_cnt_p;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][CNT_W-1:0] w_cnt_m;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][RW-1:0]    w_diff;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][RW-1:0]    r_result;

  assign w_win_done = (r_win == '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = FLUSH;
        end
      end
      FLUSH: begin
        w_state_next = (PIPE_DELAY == 0) ? ACCUM : WARMUP;
      end
      WARMUP: begin
        if (w_win_done) begin
          w_state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (w_win_done) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          w_state_next = start ? FLUSH : IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    // Abort overrides everything, including a back-to-back start.
    if (abort && (r_state != IDLE)) begin
      w_state_next = IDLE;
    end

    w_dp_rst_next = (w_state_next == FLUSH);
    w_dp_en_next  = (w_state_next == WARMUP) || (w_state_next == ACCUM);
    w_busy_next   = (w_state_next == FLUSH) || (w_state_next == WARMUP) ||
                    (w_state_next == ACCUM);
    w_valid_next  = (w_state_next == DONE);
  end

  // Outputs are registered copies of next-state decodes, so they line up with the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_dp_rst <= 1'b0;
      r_dp_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_dp_rst <= w_dp_rst_next;
      r_dp_en  <= w_dp_en_next;
      r_busy   <= w_busy_next;
      r_valid  <= w_valid_next;
    end
  end

  // Holds remaining cycles minus one of the current phase.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_win <= '0;
    end else if (w_state_next != r_state) begin
      case (w_state_next)
        WARMUP:  r_win <= WARM_LOAD;
        ACCUM:   r_win <= ACC_LOAD;
        default: r_win <= '0;
      endcase
    end else if (!w_win_done) begin
      r_win <= r_win - WIN_W'(1);
    end
  end

  assign w_clr         = (r_state == FLUSH);
  assign w_acc_en      = (r_state == ACCUM) && !abort;
  assign w_load_result = (r_state == ACCUM) && w_win_done && !abort;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      for (gj = 0; gj < NUM_COLS; gj++) begin : g_col
        logic [RW-1:0] w_sum_p;
        logic [RW-1:0] w_sum_m;

        stoch_ones_counter #(.CNT_W(CNT_W)) u_cnt_p (
          .CLK    (CLK),
          .RST    (RST),
          .clr    (w_clr),
          .en     (w_acc_en),
          .bit_in (Y_p[gi][gj]),
          .count  (w_cnt_p[gi][gj])
        );

        stoch_ones_counter #(.CNT_W(CNT_W)) u_cnt_m (
          .CLK    (CLK),
          .RST    (RST),
          .clr    (w_clr),
          .en     (w_acc_en),
          .bit_in (Y_m[gi][gj]),
          .count  (w_cnt_m[gi][gj])
        );

        // The final ACCUM sample is folded in here, not via the counter.
        assign w_sum_p = {1'b0, w_cnt_p[gi][gj]} + RW'(Y_p[gi][gj]);
        assign w_sum_m = {1'b0, w_cnt_m[gi][gj]} + RW'(Y_m[gi][gj]);
        assign w_diff[gi][gj] = w_sum_p - w_sum_m;
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_result <= '0;
    end else if (w_load_result) begin
      r_result <= w_diff;
    end
  end

  assign dp_rst       = r_dp_rst;
  assign dp_en        = r_dp_en;
  assign busy         = r_busy;
  assign result       = r_result;
  assign result_valid = r_valid;

endmodule

// File: doc/stoch_signed_mmult_window_ctrl.md
# stoch_signed_mmult_window_ctrl

Sequencer for one signed stochastic matrix multiplier. Clears the datapath, lets its pipeline fill, then counts output bitstream ones over a fixed evaluation window. Presents the per-element signed estimate (plus-count minus minus-count) to a fixed-point consumer through a valid/ready handshake. Sits between the stochastic datapath (Y_p/Y_m pairs) and deterministic logic that needs decoded results.

## Interface
- NUM_ROWS, 2, output matrix rows
- NUM_COLS, 2, output matrix columns
- WINDOW_LEN, 256, evaluation window in cycles (≥1)
- PIPE_DELAY, 2, datapath fill cycles discarded before counting (≥0)
- CNT_W, $clog2(WINDOW_LEN+1), per-stream ones-counter width (derived)
- Clock/reset (already decided): one clock; reset is synchronous and active-high.
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous reset, active-high
- start  in  1  request a new evaluation
- abort  in  1  cancel the current evaluation
- Y_p  in  [NUM_ROWS-1:0][NUM_COLS-1:0]  plus bitstreams from datapath
- Y_m  in  [NUM_ROWS-1:0][NUM_COLS-1:0]  minus bitstreams from datapath
- dp_rst  out  1  one-cycle clear pulse to datapath state
- dp_en  out  1  datapath/bitstream-source enable
- busy  out  1  evaluation in progress (FLUSH, WARMUP, ACCUM)
- result  out  [NUM_ROWS-1:0][NUM_COLS-1:0][CNT_W:0]  signed two's-complement estimate per element
- result_valid  out  1  result held and valid
- result_ready  in  1  consumer accepts result

## Operation
- States: IDLE, FLUSH, WARMUP, ACCUM, DONE.
- IDLE: start=1 → FLUSH. Otherwise stay.
- FLUSH (1 cycle): dp_rst=1, dp_en=0, all ones-counters cleared. → WARMUP, or → ACCUM if PIPE_DELAY=0.
- WARMUP (PIPE_DELAY cycles): dp_en=1. Y_p/Y_m ignored. → ACCUM.
- ACCUM (WINDOW_LEN cycles): dp_en=1. Per element, cnt_p += Y_p, cnt_m += Y_m each cycle. Counters cannot overflow: max WINDOW_LEN fits CNT_W.
- ACCUM last cycle: result register loads sign-extended cnt_p − cnt_m (final sample included), width CNT_W+1. → DONE.
- DONE: result_valid=1, dp_en=0. result stays stable until the handshake.
  - result_valid & result_ready: → IDLE.
  - If start=1 in the same cycle: → FLUSH (back-to-back).
- start outside IDLE/DONE-handshake cycle is ignored; it is not queued.
- abort=1 in FLUSH/WARMUP/ACCUM/DONE: → IDLE next cycle, result_valid drops, counters untouched until next FLUSH, result register retains its prior value. abort beats start in the same cycle.
- One window counter, width ≥ $clog2(max(WINDOW_LEN,PIPE_DELAY)), reloaded on every state entry.

## Timing
- Reset values: state=IDLE, dp_rst=0, dp_en=0, busy=0, result_valid=0, result=0, counters=0. RST dominates start/abort, and in any state takes effect at the next edge.
- start sampled at edge t in IDLE:
  - FLUSH during cycle t+1.
  - WARMUP during cycles t+2 … t+1+PIPE_DELAY.
  - ACCUM during the next WINDOW_LEN cycles.
  - result_valid first high at cycle t+2+PIPE_DELAY+WINDOW_LEN.
- Latency start→valid: 2+PIPE_DELAY+WINDOW_LEN cycles.
- Back-to-back: handshake+start at edge u → dp_rst in cycle u+1. Throughput is one result per 2+PIPE_DELAY+WINDOW_LEN cycles.
- busy=1 exactly in FLUSH, WARMUP, ACCUM. dp_en=1 exactly in WARMUP, ACCUM.
- All outputs registered. No combinational path from inputs to outputs.

## Structure
- Package stoch_ctrl_pkg: state enum typedef (ctrl_state_t), CNT_W derivation function.
- Sub-module stoch_ones_counter (parameter CNT_W; ports CLK, RST, clr, en, bit_in, count), instantiated 2×NUM_ROWS×NUM_COLS via generate.
- FSM, window counter, subtract/sign-extend and result register live in the top module.

## Test plan
Default parameters for all scenarios: NUM_ROWS=NUM_COLS=2, WINDOW_LEN=16, PIPE_DELAY=2.
- Y_p all 1, Y_m all 0 continuously, start pulse at t → dp_rst high only in t+1; result_valid at t+20; every result = +16 (6'b010000).
- Y_p=Y_m=1 → all 0. Y_p=0, Y_m=1 → all −16 (6'b110000). Y_p[0][0] toggling from ACCUM start, Y_m=0 → result[0][0]=+8.
- Y_p=1 only during WARMUP cycles, 0 during ACCUM → result all 0. Same test with PIPE_DELAY=0: ACCUM directly follows FLUSH.
- Backpressure: result_ready low 5 cycles after valid → result and result_valid stable. Ready+start in the same cycle → FLUSH next cycle, busy=1, second result correct.
- abort at 5th ACCUM cycle → IDLE next cycle, result_valid never asserts, result keeps prior value. start ignored while busy.
- RST asserted mid-ACCUM → next cycle all outputs at reset values. New start after release produces a full-latency correct result.
